// File: rtl/laser_rx_deframer.sv
// Laser photodiode byte receiver and packet deframer feeding the FTDI write path.
// Build option LASER_RX_CHECKSUM_EN adds a trailing XOR checksum byte per packet.
module laser_rx_deframer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned PKT_LEN      = 512,
    parameter logic [7:0]  SYNC         = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       laser_rx,
    output logic [7:0] data_wr,
    output logic       data_wr_valid,
    input  logic       data_wr_read,
    output logic [9:0] rx_ct,
    output logic       pkt_done,
    output logic       frame_err,
    output logic       crc_err
);
    localparam int unsigned CW  = 10;
    localparam int unsigned BCW = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    localparam logic [BCW-1:0] HALF_M1 = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0] FULL_M1 = BCW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  LEN     = CW'(PKT_LEN);
    localparam logic [CW-1:0]  LAST    = CW'(PKT_LEN - 1);
    localparam logic [AW-1:0]  A0      = '0;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] PK_HUNT    = 2'd0;
    localparam logic [1:0] PK_PAYLOAD = 2'd1;
`ifdef LASER_RX_CHECKSUM_EN
    localparam logic [1:0] PK_CHECK   = 2'd2;
`endif
    localparam logic [1:0] PK_DRAIN   = 2'd3;

    logic [1:0]     sync_q;
    logic           rx_s;
    logic [1:0]     rx_state, rx_state_nxt;
    logic [BCW-1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]     bit_idx, bit_idx_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic           byte_stb, byte_stb_nxt;
    logic [7:0]     byte_q, byte_nxt;
    logic           frame_err_nxt;

    logic [1:0]     pk_state, pk_state_nxt;
    logic [CW-1:0]  rx_ct_nxt;
    logic [CW-1:0]  rd_ptr, rd_ptr_nxt;
    logic [7:0]     data_wr_nxt;
    logic           valid_nxt;
    logic           buf_we;
    logic [AW-1:0]  buf_wa;
    logic [7:0]     buffer [0:(2**AW)-1];
`ifdef LASER_RX_CHECKSUM_EN
    logic [7:0]     csum, csum_nxt;
    logic           crc_err_nxt;
`endif

    assign rx_s     = sync_q[1];
    assign pkt_done = en & data_wr_valid & data_wr_read & (rd_ptr == LAST);

    // Bit receiver: mid-bit sampling, LSB first, one stop bit
    always_comb begin
        rx_state_nxt  = rx_state;
        bit_cnt_nxt   = bit_cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        byte_stb_nxt  = 1'b0;
        byte_nxt      = byte_q;
        frame_err_nxt = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_nxt = RX_START;
                    bit_cnt_nxt  = '0;
                end
            end
            RX_START: begin
                if (bit_cnt == HALF_M1) begin
                    bit_cnt_nxt  = '0;
                    bit_idx_nxt  = '0;
                    rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_nxt = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_nxt  = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rx_s) begin
                        byte_stb_nxt = 1'b1;
                        byte_nxt     = shreg;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
        if (!en) begin
            rx_state_nxt  = RX_IDLE;
            byte_stb_nxt  = 1'b0;
            frame_err_nxt = 1'b0;
        end
    end

    // Packet framing, buffering and drain toward the FTDI write path
    always_comb begin
        pk_state_nxt = pk_state;
        rx_ct_nxt    = rx_ct;
        rd_ptr_nxt   = rd_ptr;
        data_wr_nxt  = data_wr;
        valid_nxt    = data_wr_valid;
        buf_we       = 1'b0;
        buf_wa       = AW'(rx_ct);
`ifdef LASER_RX_CHECKSUM_EN
        csum_nxt     = csum;
        crc_err_nxt  = 1'b0;
`endif
        case (pk_state)
            PK_HUNT: begin
                if (byte_stb && (byte_q == SYNC)) begin
                    pk_state_nxt = PK_PAYLOAD;
                    rx_ct_nxt    = '0;
`ifdef LASER_RX_CHECKSUM_EN
                    csum_nxt     = '0;
`endif
                end
            end
            PK_PAYLOAD: begin
                if (frame_err) begin
                    pk_state_nxt = PK_HUNT;
                    rx_ct_nxt    = '0;
                end else if (byte_stb && (rx_ct < LEN)) begin
                    buf_we    = 1'b1;
                    rx_ct_nxt = rx_ct + 1'b1;
`ifdef LASER_RX_CHECKSUM_EN
                    csum_nxt  = csum ^ byte_q;
                    if (rx_ct == LAST) pk_state_nxt = PK_CHECK;
`else
                    if (rx_ct == LAST) begin
                        pk_state_nxt = PK_DRAIN;
                        valid_nxt    = 1'b1;
                        rd_ptr_nxt   = '0;
                        // Single-byte packets have not landed in the buffer yet
                        data_wr_nxt  = (rx_ct == '0) ? byte_q : buffer[A0];
                    end
`endif
                end
            end
`ifdef LASER_RX_CHECKSUM_EN
            PK_CHECK: begin
                if (frame_err) begin
                    pk_state_nxt = PK_HUNT;
                    rx_ct_nxt    = '0;
                end else if (byte_stb) begin
                    if (byte_q == csum) begin
                        pk_state_nxt = PK_DRAIN;
                        valid_nxt    = 1'b1;
                        rd_ptr_nxt   = '0;
                        data_wr_nxt  = buffer[A0];
                    end else begin
                        pk_state_nxt = PK_HUNT;
                        rx_ct_nxt    = '0;
                        crc_err_nxt  = 1'b1;
                    end
                end
            end
`endif
            PK_DRAIN: begin
                if (data_wr_valid && data_wr_read) begin
                    if (rd_ptr == LAST) begin
                        pk_state_nxt = PK_HUNT;
                        valid_nxt    = 1'b0;
                        rx_ct_nxt    = '0;
                        rd_ptr_nxt   = '0;
                    end else begin
                        rd_ptr_nxt  = rd_ptr + 1'b1;
                        data_wr_nxt = buffer[AW'(rd_ptr + 1'b1)];
                    end
                end
            end
            default: pk_state_nxt = PK_HUNT;
        endcase
        if (!en) begin
            pk_state_nxt = PK_HUNT;
            valid_nxt    = 1'b0;
            rx_ct_nxt    = '0;
            rd_ptr_nxt   = '0;
            buf_we       = 1'b0;
`ifdef LASER_RX_CHECKSUM_EN
            crc_err_nxt  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q        <= 2'b11;
            rx_state      <= RX_IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            byte_stb      <= 1'b0;
            byte_q        <= '0;
            frame_err     <= 1'b0;
            pk_state      <= PK_HUNT;
            rx_ct         <= '0;
            rd_ptr        <= '0;
            data_wr       <= 8'h00;
            data_wr_valid <= 1'b0;
`ifdef LASER_RX_CHECKSUM_EN
            csum          <= '0;
            crc_err       <= 1'b0;
`endif
        end else begin
            sync_q        <= {sync_q[0], laser_rx};
            rx_state      <= rx_state_nxt;
            bit_cnt       <= bit_cnt_nxt;
            bit_idx       <= bit_idx_nxt;
            shreg         <= shreg_nxt;
            byte_stb      <= byte_stb_nxt;
            byte_q        <= byte_nxt;
            frame_err     <= frame_err_nxt;
            pk_state      <= pk_state_nxt;
            rx_ct         <= rx_ct_nxt;
            rd_ptr        <= rd_ptr_nxt;
            data_wr       <= data_wr_nxt;
            data_wr_valid <= valid_nxt;
`ifdef LASER_RX_CHECKSUM_EN
            csum          <= csum_nxt;
            crc_err       <= crc_err_nxt;
`endif
        end
    end

`ifndef LASER_RX_CHECKSUM_EN
    assign crc_err = 1'b0;
`endif

    // Payload store; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (buf_we) buffer[buf_wa] <= byte_q;
    end

endmodule

// File: tb/tb_laser_rx_deframer.sv
// Directed bench for laser_rx_deframer with CLKS_PER_BIT=8, PKT_LEN=4.
// Honours LASER_RX_CHECKSUM_EN the same way as the design.
module tb_laser_rx_deframer;
    localparam int unsigned CPB = 8;

    logic       clock;
    logic       reset;
    logic       en;
    logic       laser_rx;
    logic [7:0] data_wr;
    logic       data_wr_valid;
    logic       data_wr_read;
    logic [9:0] rx_ct;
    logic       pkt_done;
    logic       frame_err;
    logic       crc_err;

    int n_checks = 0;
    int n_fail   = 0;

    laser_rx_deframer #(.CLKS_PER_BIT(CPB), .PKT_LEN(4), .SYNC(8'hA5)) dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .laser_rx      (laser_rx),
        .data_wr       (data_wr),
        .data_wr_valid (data_wr_valid),
        .data_wr_read  (data_wr_read),
        .rx_ct         (rx_ct),
        .pkt_done      (pkt_done),
        .frame_err     (frame_err),
        .crc_err       (crc_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One 10-bit frame; samples valid and frame_err one cycle before returning
    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             output logic v_before, output logic fe_at_stop);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        v_before = 1'b0;
        fe_at_stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            laser_rx = frame[i];
            for (int c = 0; c < CPB; c++) begin
                if (i == 9 && c == CPB - 1) begin
                    v_before   = data_wr_valid;
                    fe_at_stop = frame_err;
                end
                @(posedge clock);
                #1;
            end
        end
        laser_rx = 1'b1;
    endtask

    task automatic tx(input logic [7:0] b);
        logic vb, fe;
        send_byte(b, 1'b1, vb, fe);
        chk("stop_ok", 16'(fe), 16'd0);
        idle(2);
    endtask

    // SYNC + four payload bytes (+ XOR checksum); checks valid latency
    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        logic vb, fe;
        tx(8'hA5);
        tx(a);
        tx(b);
        tx(c);
`ifdef LASER_RX_CHECKSUM_EN
        tx(d);
        chk("ct_full", 16'(rx_ct), 16'd4);
        chk("no_early_valid", 16'(data_wr_valid), 16'd0);
        send_byte(a ^ b ^ c ^ d, 1'b1, vb, fe);
`else
        send_byte(d, 1'b1, vb, fe);
`endif
        chk("last_stop_ok", 16'(fe), 16'd0);
        chk("lat_pre", 16'(vb), 16'd0);
        chk("lat_rise", 16'(data_wr_valid), 16'd1);
        chk("ct_hold", 16'(rx_ct), 16'd4);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic last);
        chk("rd_valid", 16'(data_wr_valid), 16'd1);
        chk("rd_data", 16'(data_wr), 16'(exp));
        data_wr_read = 1'b1;
        #1;
        chk("pkt_done", 16'(pkt_done), 16'(last));
        @(posedge clock);
        #1;
        data_wr_read = 1'b0;
        if (last) begin
            chk("valid_drop", 16'(data_wr_valid), 16'd0);
            chk("ct_clear", 16'(rx_ct), 16'd0);
            chk("done_pulse", 16'(pkt_done), 16'd0);
        end
    endtask

    task automatic drain(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        read_byte(a, 1'b0);
        read_byte(b, 1'b0);
        read_byte(c, 1'b0);
        read_byte(d, 1'b1);
    endtask

    initial begin
        logic vb, fe;
        reset = 1'b1;
        en = 1'b1;
        laser_rx = 1'b1;
        data_wr_read = 1'b0;
        idle(3);
        chk("rst_valid", 16'(data_wr_valid), 16'd0);
        chk("rst_data", 16'(data_wr), 16'h00);
        chk("rst_ct", 16'(rx_ct), 16'd0);
        chk("rst_flags", {13'd0, pkt_done, frame_err, crc_err}, 16'd0);
        reset = 1'b0;
        idle(2);

        // Reads with nothing valid must be ignored
        data_wr_read = 1'b1;
        idle(4);
        chk("stray_read_done", 16'(pkt_done), 16'd0);
        data_wr_read = 1'b0;

        // Basic packet; consumer stalls before reading
        send_pkt(8'h01, 8'h02, 8'h03, 8'h04);
        idle(3);
        chk("stall_valid", 16'(data_wr_valid), 16'd1);
        chk("stall_data", 16'(data_wr), 16'h01);
        drain(8'h01, 8'h02, 8'h03, 8'h04);
        idle(2);

`ifdef LASER_RX_CHECKSUM_EN
        // Bad checksum
        tx(8'hA5);
        tx(8'h01);
        tx(8'h02);
        tx(8'h03);
        tx(8'h04);
        send_byte(8'hFF, 1'b1, vb, fe);
        chk("crc_pulse", 16'(crc_err), 16'd1);
        chk("crc_valid", 16'(data_wr_valid), 16'd0);
        chk("crc_ct", 16'(rx_ct), 16'd0);
        idle(1);
        chk("crc_one_cycle", 16'(crc_err), 16'd0);
        idle(2);
`endif

        // Junk before SYNC is ignored
        tx(8'h00);
        tx(8'h33);
        chk("hunt_ct", 16'(rx_ct), 16'd0);
        chk("hunt_valid", 16'(data_wr_valid), 16'd0);
        send_pkt(8'h10, 8'h20, 8'h30, 8'h40);
        drain(8'h10, 8'h20, 8'h30, 8'h40);
        idle(2);

        // Stop bit low on 2nd payload byte
        tx(8'hA5);
        tx(8'h01);
        send_byte(8'h02, 1'b0, vb, fe);
        chk("fe_pulse", 16'(fe), 16'd1);
        chk("fe_one_cycle", 16'(frame_err), 16'd0);
        chk("fe_ct", 16'(rx_ct), 16'd0);
        idle(16);
        send_pkt(8'h05, 8'h06, 8'h07, 8'h08);
        drain(8'h05, 8'h06, 8'h07, 8'h08);
        idle(2);

        // Short low glitch mid-payload yields no byte
        tx(8'hA5);
        tx(8'h11);
        laser_rx = 1'b0;
        idle(CPB / 4);
        laser_rx = 1'b1;
        idle(20);
        chk("glitch_ct", 16'(rx_ct), 16'd1);
        chk("glitch_fe", 16'(frame_err), 16'd0);
        tx(8'h22);
        tx(8'h33);
`ifdef LASER_RX_CHECKSUM_EN
        tx(8'h44);
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b1, vb, fe);
`else
        send_byte(8'h44, 1'b1, vb, fe);
`endif
        chk("glitch_lat", 16'(data_wr_valid), 16'd1);
        drain(8'h11, 8'h22, 8'h33, 8'h44);
        idle(2);

        // en dropped mid-drain
        send_pkt(8'h01, 8'h02, 8'h03, 8'h04);
        read_byte(8'h01, 1'b0);
        en = 1'b0;
        #1;
        chk("en_done_mask", 16'(pkt_done), 16'd0);
        idle(1);
        chk("en_valid", 16'(data_wr_valid), 16'd0);
        chk("en_ct", 16'(rx_ct), 16'd0);
        en = 1'b1;
        idle(4);
        chk("en_stay_idle", 16'(data_wr_valid), 16'd0);
        send_pkt(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        drain(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        idle(2);

        // Asynchronous reset mid-payload, then normal reception
        tx(8'hA5);
        tx(8'h01);
        chk("pre_rst_ct", 16'(rx_ct), 16'd1);
        reset = 1'b1;
        #1;
        chk("arst_data", 16'(data_wr), 16'h00);
        chk("arst_ct", 16'(rx_ct), 16'd0);
        chk("arst_flags", {12'd0, data_wr_valid, pkt_done, frame_err, crc_err}, 16'd0);
        idle(2);
        reset = 1'b0;
        idle(4);
        send_pkt(8'h21, 8'h22, 8'h23, 8'h24);
        drain(8'h21, 8'h22, 8'h23, 8'h24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
